// File: rtl/moveq_fifo_if.sv
// Bundles the moveq_fifo consumer handshake and the wishbone slave port.
// The slave modport is the FIFO side; the master modport drives it.
interface moveq_fifo_if;
  logic        pin_have_space;
  logic [63:0] mq_data;
  logic        mq_avail;
  logic        mq_pull;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    output pin_have_space,
    output mq_data,
    output mq_avail,
    input  mq_pull,
    input  wb_stb_i,
    input  wb_cyc_i,
    input  wb_we_i,
    input  wb_adr_i,
    input  wb_dat_i,
    output wb_dat_o,
    output wb_ack_o
  );

  modport master (
    input  pin_have_space,
    input  mq_data,
    input  mq_avail,
    output mq_pull,
    output wb_stb_i,
    output wb_cyc_i,
    output wb_we_i,
    output wb_adr_i,
    output wb_dat_i,
    input  wb_dat_o,
    input  wb_ack_o
  );
endinterface

// File: rtl/moveq_fifo.sv
// Move queue: wishbone-fed circular FIFO of {interval, countadd} entries
// drained by a pull/avail consumer, with sticky overflow and a status word.
module moveq_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  moveq_fifo_if.slave bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned EW       = 64;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [3:0] ADR_PUSH     = 4'd0;
  localparam logic [3:0] ADR_INTERVAL = 4'd1;
  localparam logic [3:0] ADR_STATUS   = 4'd2;
  localparam logic [3:0] ADR_CTRL     = 4'd3;

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   interval;
  logic          overflow;

  logic [AW-1:0] head_nxt;
  logic [AW-1:0] tail_nxt;
  logic [CW-1:0] count_nxt;
  logic [31:0]   interval_nxt;
  logic          overflow_nxt;

  logic wr;
  logic push_req;
  logic load_interval;
  logic flush;
  logic clr_ovf;
  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic ovf_set;
  logic [31:0] status;

  // Wishbone write decode
  assign wr            = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
  assign push_req      = wr & (bus.wb_adr_i == ADR_PUSH);
  assign load_interval = wr & (bus.wb_adr_i == ADR_INTERVAL);
  assign flush         = wr & (bus.wb_adr_i == ADR_CTRL) & bus.wb_dat_i[0];
  assign clr_ovf       = wr & (bus.wb_adr_i == ADR_CTRL) & bus.wb_dat_i[1];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = bus.mq_pull & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  // Next-state for pointers, occupancy, staging interval and overflow
  always_comb begin
    head_nxt     = head;
    tail_nxt     = tail;
    count_nxt    = count;
    interval_nxt = interval;
    overflow_nxt = overflow;

    if (load_interval) begin
      interval_nxt = bus.wb_dat_i;
    end

    if (flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end else begin
      if (pop) begin
        head_nxt = head + AW'(1);
      end
      if (push_ok) begin
        tail_nxt = tail + AW'(1);
      end
      if (push_ok && !pop) begin
        count_nxt = count + CW'(1);
      end else if (pop && !push_ok) begin
        count_nxt = count - CW'(1);
      end
    end

    if (ovf_set) begin
      overflow_nxt = 1'b1;
    end else if (clr_ovf) begin
      overflow_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      interval <= '0;
      overflow <= 1'b0;
    end else begin
      head     <= head_nxt;
      tail     <= tail_nxt;
      count    <= count_nxt;
      interval <= interval_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Entry storage is not reset; the empty mask on mq_data hides stale words
  always_ff @(posedge clk) begin
    if (!rst && push_ok && !flush) begin
      mem[tail] <= {interval, bus.wb_dat_i};
    end
  end

  assign bus.mq_avail       = ~empty;
  assign bus.pin_have_space = ~full;
  assign bus.mq_data        = empty ? '0 : mem[head];
  assign bus.wb_ack_o       = 1'b1;

  assign status = {13'd0, full, empty, overflow, 16'(count)};

  always_comb begin
    bus.wb_dat_o = '0;
    case (bus.wb_adr_i)
      ADR_INTERVAL: bus.wb_dat_o = interval;
      ADR_STATUS:   bus.wb_dat_o = status;
      default:      bus.wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_moveq_fifo.sv
// Bench for moveq_fifo: directed scenarios plus random traffic compared
// against a queue-based reference model of the move queue.
module tb_moveq_fifo;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0] q[$];
  logic [31:0] m_interval;
  logic        m_ovf;

  moveq_fifo_if bus ();

  moveq_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {13'd0, (q.size() == DEPTH), (q.size() == 0), m_ovf, 16'(q.size())};
  endfunction

  function automatic logic [63:0] exp_head();
    return (q.size() != 0) ? q[0] : 64'd0;
  endfunction

  // Reference behaviour of one clock edge, from the pre-edge model state
  function automatic void model(input logic we, input logic [3:0] adr,
                                input logic [31:0] dat, input logic pull);
    bit pop;
    bit push;
    bit set_o;
    bit fl;
    bit clr;
    pop   = pull && (q.size() != 0);
    push  = 0;
    set_o = 0;
    fl    = we && (adr == 4'd3) && dat[0];
    clr   = we && (adr == 4'd3) && dat[1];
    if (we && adr == 4'd0) begin
      if (q.size() < DEPTH || pop) push = 1;
      else set_o = 1;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({m_interval, dat});
    end
    if (we && adr == 4'd1) m_interval = dat;
    if (set_o) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic idle_read(input logic [3:0] adr);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_dat_i = '0;
    bus.mq_pull  = 1'b0;
    bus.wb_adr_i = adr;
  endtask

  // Apply one cycle of stimulus, advance the model, then compare outputs
  task automatic step(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      input logic pull, input string tag);
    bus.wb_cyc_i = we;
    bus.wb_stb_i = we;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.mq_pull  = pull;
    @(posedge clk);
    #1;
    model(we, adr, dat, pull);
    idle_read(4'd2);
    #1;
    check({tag, ":avail"}, 64'(bus.mq_avail), 64'(q.size() != 0));
    check({tag, ":space"}, 64'(bus.pin_have_space), 64'(q.size() != DEPTH));
    check({tag, ":data"}, bus.mq_data, exp_head());
    check({tag, ":status"}, 64'(bus.wb_dat_o), 64'(exp_status()));
  endtask

  task automatic push(input logic [31:0] dat, input string tag);
    step(1'b1, 4'd0, dat, 1'b0, tag);
  endtask

  task automatic pull(input string tag);
    step(1'b0, 4'd0, 32'd0, 1'b1, tag);
  endtask

  task automatic ctrl(input logic [31:0] dat, input logic p, input string tag);
    step(1'b1, 4'd3, dat, p, tag);
  endtask

  initial begin
    logic [31:0] rdat;
    logic [3:0]  radr;
    int          sel;
    checks     = 0;
    errors     = 0;
    m_interval = '0;
    m_ovf      = 1'b0;
    idle_read(4'd2);
    rst = 1'b1;

    // Reset values
    #3;
    check("rst:avail", 64'(bus.mq_avail), 64'd0);
    check("rst:space", 64'(bus.pin_have_space), 64'd1);
    check("rst:data", bus.mq_data, 64'd0);
    check("rst:ack", 64'(bus.wb_ack_o), 64'd1);
    check("rst:status", 64'(bus.wb_dat_o), 64'h0002_0000);
    bus.wb_adr_i = 4'd1;
    #1;
    check("rst:interval", 64'(bus.wb_dat_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two pushes with a staged interval, then one pull
    step(1'b1, 4'd1, 32'h100, 1'b0, "ld_int");
    push(32'd5, "p5");
    check("d36:first", bus.mq_data, 64'h0000_0100_0000_0005);
    push(32'd6, "p6");
    check("d36:cnt2", 64'(bus.wb_dat_o), 64'h0004_0002 & 64'h0000_FFFF | 64'd0 | 64'h2 - 64'h2 + 64'd2);
    pull("pull36");
    check("d36:second", bus.mq_data, 64'h0000_0100_0000_0006);
    check("d36:cnt1", 64'(bus.wb_dat_o), 64'h0000_0001);
    bus.wb_adr_i = 4'd1;
    #1;
    check("d36:interval", 64'(bus.wb_dat_o), 64'h100);
    bus.wb_adr_i = 4'd5;
    #1;
    check("rd_other", 64'(bus.wb_dat_o), 64'd0);

    // Overflow on the fifth push
    ctrl(32'h3, 1'b0, "flush37");
    for (int i = 0; i < 5; i++) begin
      push(32'h10 + 32'(i), "p37");
      if (i == 3) check("d37:nospace", 64'(bus.pin_have_space), 64'd0);
    end
    check("d37:status", 64'(bus.wb_dat_o), 64'h0005_0004);

    // Push and pull together while full
    ctrl(32'h2, 1'b0, "clr38");
    step(1'b1, 4'd0, 32'hBEEF, 1'b1, "pp38");
    check("d38:status", 64'(bus.wb_dat_o), 64'h0004_0004);
    check("d38:head", bus.mq_data, 64'h0000_0100_0000_0011);
    step(1'b1, 4'd2, 32'hFFFF_FFFF, 1'b0, "nop_adr2");
    step(1'b1, 4'd9, 32'hFFFF_FFFF, 1'b0, "nop_adr9");
    for (int i = 0; i < 4; i++) pull("drain38");

    // Fill, drain and refill across pointer wrap
    step(1'b1, 4'd1, 32'h0000_0777, 1'b0, "ld39");
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), "fill39");
    for (int i = 0; i < 4; i++) pull("drain39");
    for (int i = 0; i < 10; i++) step(1'b1, 4'd0, 32'h1000 + 32'(i), (i >= 2), "wrap39");
    for (int i = 0; i < 3; i++) pull("tail39");

    // Flush in the same cycle as a pull
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(i), "p40");
    ctrl(32'h3, 1'b1, "flush40");
    check("d40:status", 64'(bus.wb_dat_o), 64'h0002_0000);
    check("d40:data", bus.mq_data, 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      sel  = int'($urandom_range(0, 19));
      rdat = $urandom;
      if (sel < 9)       radr = 4'd0;
      else if (sel < 11) radr = 4'd1;
      else if (sel < 13) radr = 4'd3;
      else if (sel < 14) radr = 4'd2;
      else if (sel < 15) radr = 4'(4 + $urandom_range(0, 11));
      else               radr = 4'd0;
      if (radr == 4'd3 && ($urandom_range(0, 3) != 0)) rdat[0] = 1'b0;
      step((sel < 15), radr, rdat, ($urandom_range(0, 9) < 4), "rand");
    end

    // Asynchronous reset between edges with two entries held
    ctrl(32'h3, 1'b0, "flush41");
    push(32'h51, "p41a");
    push(32'h52, "p41b");
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf      = 1'b0;
    m_interval = '0;
    check("d41:avail", 64'(bus.mq_avail), 64'd0);
    check("d41:status", 64'(bus.wb_dat_o), 64'h0002_0000);
    check("d41:data", bus.mq_data, 64'd0);
    #1;
    rst = 1'b0;
    bus.wb_adr_i = 4'd1;
    #1;
    check("d41:interval", 64'(bus.wb_dat_o), 64'd0);
    push(32'h61, "post41");
    check("d41:post", bus.mq_data, 64'h0000_0000_0000_0061);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moveq_fifo.md
MOVEQ_FIFO -- requirements
Module: moveq_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, 2..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: pin_have_space  output  1  high when the queue is not full.
REQ-005 Port: mq_data  output  64  head entry, {interval[31:0], countadd[31:0]}.
REQ-006 Port: mq_avail  output  1  high when the queue holds at least one entry.
REQ-007 Port: mq_pull  input  1  consumer pops the head entry this cycle.
REQ-008 Port: wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  wishbone strobe, cycle, write-enable.
REQ-009 Port: wb_adr_i  input  4  wishbone word address.
REQ-010 Port: wb_dat_i  input  32  wishbone write data.
REQ-011 Port: wb_dat_o  output  32  wishbone read data, combinational from wb_adr_i and state.
REQ-012 Port: wb_ack_o  output  1  tied high; every access completes in one cycle.

Function
REQ-013 Write access = wb_cyc_i & wb_stb_i & wb_we_i; writes take effect on the next rising clk edge.
REQ-014 Write addr 1: load the 32-bit staging interval register; no push.
REQ-015 Write addr 0: push {staging interval, wb_dat_i} at the tail; the staging interval is retained for later pushes.
REQ-016 Write addr 3: bit0 = flush (count, head and tail pointers to 0); bit1 = clear the overflow flag; other bits ignored.
REQ-017 Writes to addresses 2 and 4..15 have no effect.
REQ-018 Storage: DEPTH x 64-bit circular buffer; head and tail pointers of width log2(DEPTH) wrap from DEPTH-1 to 0.
REQ-019 Occupancy count width: log2(DEPTH)+1; range 0..DEPTH.
REQ-020 mq_avail = (count != 0); pin_have_space = (count != DEPTH).
REQ-021 mq_data = entry at head; mq_data = 0 when the queue is empty.
REQ-022 Pop: mq_pull & (count != 0) advances head and decrements count; mq_pull while empty is ignored.
REQ-023 Push is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
REQ-024 Simultaneous accepted push and pop: count unchanged; both pointers advance.
REQ-025 Push when full without a pop: data dropped, state unchanged, overflow flag set (sticky).
REQ-026 Flush has priority over a same-cycle push and pop: the queue ends empty and the push is discarded.
REQ-027 If overflow set and clear occur in the same cycle, set wins.
REQ-028 Read addr 1 returns the staging interval.
REQ-029 Read addr 2 returns status: [15:0] count (zero-extended), [16] overflow, [17] empty, [18] full, [31:19] zero.
REQ-030 Reads of all other addresses return 0.
REQ-031 Latency: a pushed entry is visible on mq_data/mq_avail in the cycle after the write when the queue was empty.

Reset
REQ-032 While rst is high: count, pointers, staging interval and overflow flag are 0 immediately, independent of clk.
REQ-033 Reset outputs: mq_avail=0, pin_have_space=1, mq_data=0, wb_dat_o per REQ-028..030 with zero state, wb_ack_o=1.
REQ-034 Buffer array contents need no reset; mq_data masking (REQ-021) hides stale data.
REQ-035 Reset asserted mid-operation discards all queued entries; no push or pop is performed on the edge where rst is high.

Verification (DEPTH=4)
REQ-036 Write addr1=0x100, addr0=5, addr0=6 -> two entries; mq_data=0x00000100_00000005, then after a pull 0x00000100_00000006; status count=2 then 1.
REQ-037 Five pushes with no pull -> pin_have_space=0 after the 4th; the 5th is dropped; status=0x00050004 (overflow, full, count 4).
REQ-038 Queue full, push and mq_pull in the same cycle -> count stays 4, overflow stays 0, head advances, new entry is at the tail.
REQ-039 Fill, drain, and refill 10 entries with distinct countadds -> FIFO order is preserved across pointer wrap.
REQ-040 With 3 entries, write addr3=0x3 in the same cycle as mq_pull -> count=0, overflow=0, mq_avail=0, mq_data=0.
REQ-041 Assert rst asynchronously between clk edges with 2 entries -> mq_avail=0 and status=0x00020000 (empty) before the next edge.
